cpu_mc_ctrl: RTL and testbench
==============================

Name: cpu_mc_ctrl

Overview:
- Multi-cycle sequencing controller for the single-ALU CPU datapath.
- Steps each instruction through IF/ID/EX/MEM/WB and drives the stage enables, PC write/select, memory request handshake and register write-back.
- Latches the ALU opcode and consumes the ALU branch flag (ife).
- Counts retired instructions and flags memory timeouts and illegal opcodes.

Parameters:
TIMEOUT, 16, max cycles mem_req may stay unacknowledged before the error state
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
run  in  1  start execution; sampled only in IDLE
opcode  in  6  instruction opcode field from the fetched instruction word
ife  in  1  branch-taken flag from the ALU, valid during EX
mem_ready  in  1  memory acknowledge for the current mem_req
ir_we  out  1  instruction register load (IF, on mem_ready)
alu_op  out  6  registered opcode presented to the ALU
ex_en  out  1  ALU operand/result register enable
mem_req  out  1  memory request (IF and MEM)
mem_we  out  1  memory write qualifier (MEM of SW only)
reg_we  out  1  register file write enable
wb_sel  out  1  write-back source: 0 = ALU result, 1 = load data
pc_we  out  1  PC update strobe; one pulse per retired instruction
pc_sel  out  1  PC source: 0 = npc, 1 = ALU addr_o
busy  out  1  high in every state except IDLE, HALT and ERR
halted  out  1  HALT state reached
err  out  1  sticky error: timeout or illegal opcode
instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst=1): state=IDLE, alu_op=0, wait_cnt=0, instr_cnt=0, all strobes and status outputs 0. Reset mid-instruction aborts it with no pc_we or reg_we pulse.
- Outputs are decoded from the registered state (Moore style), except ir_we, pc_sel and the MEM-exit pc_we, which also qualify on mem_ready or ife in the same cycle.
- Opcodes (package constants):
  - OP_NOP 000000
  - OP_ALU 000001
  - OP_ADDI 001000
  - OP_LW 100011
  - OP_SW 101011
  - OP_BEQZ 000100
  - OP_J 000010
  - OP_HALT 111111
  - Any other value is illegal.
- State transitions:
  - IDLE: run=1 -> IF.
  - IF: mem_req=1. On mem_ready, ir_we=1 -> ID.
  - ID: alu_op<=opcode. HALT -> HALT; illegal -> ERR; otherwise -> EX.
  - EX: ex_en=1.
    - ALU/ADDI -> WB.
    - LW/SW -> MEM.
    - NOP: pc_we=1, pc_sel=0 -> IF.
    - J: pc_we=1, pc_sel=1 -> IF.
    - BEQZ: pc_we=1, pc_sel=ife -> IF.
  - MEM: mem_req=1, mem_we=(alu_op==SW). On mem_ready: LW -> WB; SW -> pc_we=1, pc_sel=0 -> IF.
  - WB: reg_we=1, wb_sel=(alu_op==LW), pc_we=1, pc_sel=0 -> IF.
  - HALT: halted=1; held until reset.
  - ERR: err=1; held until reset. run is ignored in both.
- Timeout:
  - wait_cnt increments each IF/MEM cycle with mem_ready=0 and clears on state change.
  - If wait_cnt reaches TIMEOUT-1 and mem_ready=0, next state is ERR. mem_ready in that same cycle wins.
- Latency with zero-wait memory:
  - NOP/J/BEQZ: 3 cycles.
  - ALU/ADDI/SW: 4 cycles.
  - LW: 5 cycles.
  - Each memory wait cycle adds 1.
- instr_cnt increments on every pc_we pulse and wraps at 2^CNT_W. HALT does not count.
- pc_we, reg_we and ir_we are never high for more than one cycle per instruction.

Decomposition:
- Package cpu_pkg: opcode localparams, state encoding (IDLE, IF, ID, EX, MEM, WB, HALT, ERR as a 3-bit enum), is_legal/is_mem decode functions.
- One sub-module: cpu_mem_timeout, containing the wait_cnt counter and compare (inputs: active, ready; output: expire).

Test Plan:
- ALU instr, mem_ready always 1, run pulse: ir_we at cycle 1, ex_en at 3, reg_we and pc_we with pc_sel=0 at cycle 4, instr_cnt=1.
- LW with mem_ready delayed 2 cycles in MEM: pc_we 7 cycles after IF entry, wb_sel=1 with reg_we; SW: mem_we=1 only in MEM, no reg_we.
- BEQZ with ife=1 -> pc_sel=1 at EX; BEQZ with ife=0 -> pc_sel=0; both 3 cycles, instr_cnt +1 each.
- mem_ready held 0 in IF with TIMEOUT=16: err=1 after 16 IF cycles, busy=0, no further mem_req. Repeat with mem_ready arriving on cycle 16: no error.
- Illegal opcode 6'b010101 -> ERR after ID. HALT opcode -> halted=1 with instr_cnt unchanged; run=1 afterwards is ignored.
- rst asserted asynchronously during MEM: all outputs 0 immediately, state IDLE; next run restarts at IF with instr_cnt=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU sequencing controller.
//   - opcode constants decoded by the controller
//   - state encoding (3-bit enum)
//   - is_legal / is_mem opcode decode helpers
package cpu_pkg;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_ALU  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQZ = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IF   = 3'd1,
        ST_ID   = 3'd2,
        ST_EX   = 3'd3,
        ST_MEM  = 3'd4,
        ST_WB   = 3'd5,
        ST_HALT = 3'd6,
        ST_ERR  = 3'd7
    } state_t;

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            OP_NOP, OP_ALU, OP_ADDI, OP_LW, OP_SW,
            OP_BEQZ, OP_J, OP_HALT: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/cpu_mc_ctrl_if.sv
// Handshake/control bundle between the sequencing controller and the datapath.
//   master : controller side (drives strobes, alu_op, status, instr_cnt)
//   slave  : datapath/environment side (drives run, opcode, ife, mem_ready)
interface cpu_mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             run;
    logic [5:0]       opcode;
    logic             ife;
    logic             mem_ready;
    logic             ir_we;
    logic [5:0]       alu_op;
    logic             ex_en;
    logic             mem_req;
    logic             mem_we;
    logic             reg_we;
    logic             wb_sel;
    logic             pc_we;
    logic             pc_sel;
    logic             busy;
    logic             halted;
    logic             err;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  run, opcode, ife, mem_ready,
        output ir_we, alu_op, ex_en, mem_req, mem_we, reg_we, wb_sel,
               pc_we, pc_sel, busy, halted, err, instr_cnt
    );

    modport slave (
        output run, opcode, ife, mem_ready,
        input  ir_we, alu_op, ex_en, mem_req, mem_we, reg_we, wb_sel,
               pc_we, pc_sel, busy, halted, err, instr_cnt
    );
endinterface

// File: rtl/cpu_mem_timeout.sv
// Memory wait watchdog.
//   clk, rst : clock, async active-high reset
//   active   : controller is in a state holding mem_req (IF or MEM)
//   ready    : memory acknowledge
//   expire   : last allowed unacknowledged cycle reached with no ready
module cpu_mem_timeout #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    output logic expire
);
    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] wait_cnt;

    // Any exit from the waiting state (ready, expiry or leaving IF/MEM) clears the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!active || ready || expire) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign expire = active && !ready && (wait_cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_mc_ctrl.sv
// Multi-cycle sequencing controller: steps each instruction through
// IF/ID/EX/MEM/WB, drives stage enables, PC update, memory handshake and
// write-back, counts retired instructions, flags timeouts / illegal opcodes.
//   clk, rst : clock, async active-high reset
//   bus      : cpu_mc_ctrl_if master modport (run/opcode/ife/mem_ready in,
//              strobes, alu_op, status and instr_cnt out)
//
// state | meaning
// IDLE  | waiting for run
// IF    | fetch request, load IR on mem_ready
// ID    | latch opcode, decode
// EX    | ALU step; jumps/branches/NOP retire here
// MEM   | data memory access (LW/SW)
// WB    | register write-back, retire
// HALT  | stopped by HALT opcode until reset
// ERR   | memory timeout or illegal opcode until reset
module cpu_mc_ctrl
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic          clk,
    input  logic          rst,
    cpu_mc_ctrl_if.master bus
);
    state_t           state, state_nx;
    logic [5:0]       alu_op;
    logic [CNT_W-1:0] instr_cnt;
    logic             mem_active;
    logic             expire;
    logic             ir_we, ex_en, mem_req, mem_we, reg_we, wb_sel, pc_we, pc_sel;

    assign mem_active = (state == ST_IF) || (state == ST_MEM);

    cpu_mem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .active (mem_active),
        .ready  (bus.mem_ready),
        .expire (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            alu_op    <= '0;
            instr_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_ID) begin
                alu_op <= bus.opcode;
            end
            if (pc_we) begin
                instr_cnt <= instr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ir_we    = 1'b0;
        ex_en    = 1'b0;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.run) state_nx = ST_IF;
            end
            ST_IF: begin
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_we    = 1'b1;
                    state_nx = ST_ID;
                end else if (expire) begin
                    state_nx = ST_ERR;
                end
            end
            ST_ID: begin
                // Decode straight from the bus; alu_op only holds it from EX onwards.
                if (bus.opcode == OP_HALT)      state_nx = ST_HALT;
                else if (!is_legal(bus.opcode)) state_nx = ST_ERR;
                else                            state_nx = ST_EX;
            end
            ST_EX: begin
                ex_en = 1'b1;
                case (alu_op)
                    OP_ALU, OP_ADDI: state_nx = ST_WB;
                    OP_LW, OP_SW:    state_nx = ST_MEM;
                    OP_NOP: begin
                        pc_we    = 1'b1;
                        state_nx = ST_IF;
                    end
                    OP_J: begin
                        pc_we    = 1'b1;
                        pc_sel   = 1'b1;
                        state_nx = ST_IF;
                    end
                    OP_BEQZ: begin
                        pc_we    = 1'b1;
                        pc_sel   = bus.ife;
                        state_nx = ST_IF;
                    end
                    default: state_nx = ST_ERR;
                endcase
            end
            ST_MEM: begin
                mem_req = 1'b1;
                mem_we  = (alu_op == OP_SW);
                if (bus.mem_ready) begin
                    if (alu_op == OP_SW) begin
                        pc_we    = 1'b1;
                        state_nx = ST_IF;
                    end else begin
                        state_nx = ST_WB;
                    end
                end else if (expire) begin
                    state_nx = ST_ERR;
                end
            end
            ST_WB: begin
                reg_we   = 1'b1;
                wb_sel   = (alu_op == OP_LW);
                pc_we    = 1'b1;
                state_nx = ST_IF;
            end
            ST_HALT: state_nx = ST_HALT;
            ST_ERR:  state_nx = ST_ERR;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus.ir_we     = ir_we;
    assign bus.alu_op    = alu_op;
    assign bus.ex_en     = ex_en;
    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_we;
    assign bus.reg_we    = reg_we;
    assign bus.wb_sel    = wb_sel;
    assign bus.pc_we     = pc_we;
    assign bus.pc_sel    = pc_sel;
    assign bus.busy      = (state != ST_IDLE) && (state != ST_HALT) && (state != ST_ERR);
    assign bus.halted    = (state == ST_HALT);
    assign bus.err       = (state == ST_ERR);
    assign bus.instr_cnt = instr_cnt;

endmodule

// File: tb/tb_cpu_mc_ctrl.sv
// Self-checking bench for cpu_mc_ctrl: expected per-instruction records are
// queued when an instruction is issued and compared once it retires or stops.
module tb_cpu_mc_ctrl;
    import cpu_pkg::*;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_mc_ctrl_if #(.CNT_W(CNT_W)) bus ();

    cpu_mc_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Relative cycle numbers count from the first IF cycle (= 1).
    typedef struct packed {
        logic [7:0] ir_rel, ex_rel, pc_rel, end_rel;
        logic [7:0] ir_n, ex_n, reg_n, mem_we_n, pc_n;
        logic       pc_sel, wb_sel, err, halted, tmo;
    } rec_t;

    typedef struct packed {
        logic [5:0] op;
        logic       ife;
        logic [7:0] if_w, mem_w;
    } stim_t;

    rec_t             exp_q[$];
    int               checks   = 0;
    int               failures = 0;
    logic [CNT_W-1:0] model_cnt;

    function automatic rec_t expect_rec(input logic [5:0] op, input logic ife_v,
                                        input int if_wait, input int mem_wait);
        rec_t e = '0;
        if (if_wait >= TIMEOUT) begin
            e.end_rel = 8'(TIMEOUT + 1);
            e.err     = 1'b1;
            return e;
        end
        e.ir_rel = 8'(if_wait + 1);
        e.ir_n   = 8'd1;
        if (op == OP_HALT) begin
            e.end_rel = 8'(if_wait + 3);
            e.halted  = 1'b1;
            return e;
        end
        if (!(op inside {OP_NOP, OP_ALU, OP_ADDI, OP_LW, OP_SW, OP_BEQZ, OP_J})) begin
            e.end_rel = 8'(if_wait + 3);
            e.err     = 1'b1;
            return e;
        end
        e.ex_rel = 8'(if_wait + 3);
        e.ex_n   = 8'd1;
        e.pc_n   = 8'd1;
        case (op)
            OP_ALU, OP_ADDI: begin
                e.pc_rel = 8'(if_wait + 4);
                e.reg_n  = 8'd1;
            end
            OP_SW: begin
                e.pc_rel   = 8'(if_wait + 4 + mem_wait);
                e.mem_we_n = 8'(mem_wait + 1);
            end
            OP_LW: begin
                e.pc_rel = 8'(if_wait + 5 + mem_wait);
                e.reg_n  = 8'd1;
                e.wb_sel = 1'b1;
            end
            default: e.pc_rel = 8'(if_wait + 3);
        endcase
        e.pc_sel = (op == OP_J) || ((op == OP_BEQZ) && ife_v);
        return e;
    endfunction

    task automatic do_reset();
        rst           = 1'b1;
        bus.run       = 1'b0;
        bus.opcode    = OP_NOP;
        bus.ife       = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        model_cnt = '0;
        exp_q.delete();
    endtask

    // Drives one instruction; memory acks after if_wait / mem_wait stalled cycles.
    task automatic exec_instr(input logic [5:0] op, input logic ife_v, input int if_wait,
                              input int mem_wait, output rec_t o, output logic [CNT_W-1:0] c);
        int cyc = 0, if_cyc = -1, if_w = 0, mem_w = 0, rel;
        bit ir_seen = 0, done = 0, retired = 0;
        o = '0;
        while (!done) begin
            @(negedge clk);
            #1;
            bus.opcode = op;
            bus.ife    = ife_v;
            if (bus.mem_req && if_cyc < 0) if_cyc = cyc;
            if (bus.mem_req && !ir_seen) begin
                bus.mem_ready = (if_w >= if_wait);
                if_w++;
            end else if (bus.mem_req) begin
                bus.mem_ready = (mem_w >= mem_wait);
                mem_w++;
            end else begin
                bus.mem_ready = 1'b0;
            end
            #1;
            rel = (if_cyc < 0) ? 0 : cyc - if_cyc + 1;
            if (bus.ir_we) begin
                o.ir_n = o.ir_n + 1'b1;
                if (o.ir_rel == 0) o.ir_rel = 8'(rel);
                ir_seen = 1;
            end
            if (bus.ex_en) begin
                o.ex_n = o.ex_n + 1'b1;
                if (o.ex_rel == 0) o.ex_rel = 8'(rel);
            end
            if (bus.mem_we) o.mem_we_n = o.mem_we_n + 1'b1;
            if (bus.reg_we) begin
                o.reg_n  = o.reg_n + 1'b1;
                o.wb_sel = bus.wb_sel;
            end
            if (bus.pc_we) begin
                o.pc_n   = o.pc_n + 1'b1;
                o.pc_rel = 8'(rel);
                o.pc_sel = bus.pc_sel;
                done     = 1;
                retired  = 1;
            end
            if (bus.err || bus.halted) begin
                o.end_rel = 8'(rel);
                o.err     = bus.err;
                o.halted  = bus.halted;
                done      = 1;
            end
            cyc++;
            if (!done && cyc >= 80) begin
                o.tmo = 1'b1;
                done  = 1;
            end
        end
        if (retired) begin
            @(posedge clk);
            #1;
        end
        c = bus.instr_cnt;
    endtask

    task automatic issue(input stim_t s, output rec_t o, output logic [CNT_W-1:0] c);
        rec_t e;
        e = expect_rec(s.op, s.ife, int'(s.if_w), int'(s.mem_w));
        exp_q.push_back(e);
        if (e.pc_n != 0) model_cnt = model_cnt + 1'b1;
        exec_instr(s.op, s.ife, int'(s.if_w), int'(s.mem_w), o, c);
    endtask

    task automatic test_reset();
        logic [31:0] vec;
        rst           = 1'b1;
        bus.run       = 1'b1;
        bus.opcode    = OP_ALU;
        bus.ife       = 1'b1;
        bus.mem_ready = 1'b1;
        #1;
        vec = {bus.ir_we, bus.alu_op, bus.ex_en, bus.mem_req, bus.mem_we, bus.reg_we,
               bus.wb_sel, bus.pc_we, bus.pc_sel, bus.busy, bus.halted, bus.err, 12'd0};
        checks++;
        if (vec !== 32'd0 || bus.instr_cnt !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h cnt %0d required 0", vec, bus.instr_cnt);
        end
        do_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.mem_req} !== 2'b00) begin
            failures++;
            $display("FAIL reset_idle_no_run: busy/mem_req %b required 00", {bus.busy, bus.mem_req});
        end
    endtask

    task automatic test_alu();
        stim_t tbl[3];
        rec_t o, e;
        logic [CNT_W-1:0] c;
        tbl[0] = '{OP_ALU, 1'b0, 8'd0, 8'd0};
        tbl[1] = '{OP_ADDI, 1'b0, 8'd0, 8'd0};
        tbl[2] = '{OP_ALU, 1'b1, 8'd2, 8'd0};
        do_reset();
        bus.run = 1'b1;
        foreach (tbl[i]) begin
            issue(tbl[i], o, c);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL alu_rec[%0d]: got %h required %h", i, o, e);
            end
            checks++;
            if (c !== model_cnt) begin
                failures++;
                $display("FAIL alu_cnt[%0d]: got %0d required %0d", i, c, model_cnt);
            end
        end
    endtask

    task automatic test_load_store();
        stim_t tbl[4];
        rec_t o, e;
        logic [CNT_W-1:0] c;
        tbl[0] = '{OP_LW, 1'b0, 8'd0, 8'd2};
        tbl[1] = '{OP_SW, 1'b0, 8'd0, 8'd0};
        tbl[2] = '{OP_SW, 1'b1, 8'd1, 8'd3};
        tbl[3] = '{OP_LW, 1'b0, 8'd1, 8'd0};
        foreach (tbl[i]) begin
            issue(tbl[i], o, c);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL ldst_rec[%0d]: got %h required %h", i, o, e);
            end
            checks++;
            if (c !== model_cnt) begin
                failures++;
                $display("FAIL ldst_cnt[%0d]: got %0d required %0d", i, c, model_cnt);
            end
        end
    endtask

    task automatic test_branch();
        stim_t tbl[4];
        rec_t o, e;
        logic [CNT_W-1:0] c;
        tbl[0] = '{OP_BEQZ, 1'b1, 8'd0, 8'd0};
        tbl[1] = '{OP_BEQZ, 1'b0, 8'd0, 8'd0};
        tbl[2] = '{OP_J, 1'b0, 8'd0, 8'd0};
        tbl[3] = '{OP_NOP, 1'b1, 8'd0, 8'd0};
        foreach (tbl[i]) begin
            issue(tbl[i], o, c);
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL branch_rec[%0d]: got %h required %h", i, o, e);
            end
            checks++;
            if (c !== model_cnt) begin
                failures++;
                $display("FAIL branch_cnt[%0d]: got %0d required %0d", i, c, model_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[7];
        stim_t s;
        rec_t o, e;
        logic [CNT_W-1:0] c;
        ops = '{OP_NOP, OP_ALU, OP_ADDI, OP_LW, OP_SW, OP_BEQZ, OP_J};
        for (int i = 0; i < 24; i++) begin
            s.op    = ops[$urandom_range(6)];
            s.ife   = 1'($urandom_range(1));
            s.if_w  = 8'($urandom_range(2));
            s.mem_w = 8'($urandom_range(3));
            issue(s, o, c);
            e = exp_q.pop_front();
            checks++;
            if (o !== e || c !== model_cnt) begin
                failures++;
                $display("FAIL b2b[%0d] op %b: got %h cnt %0d required %h cnt %0d",
                         i, s.op, o, c, e, model_cnt);
            end
        end
    endtask

    task automatic test_timeout();
        stim_t s;
        rec_t o, e;
        logic [CNT_W-1:0] c;
        bit bad = 0;
        do_reset();
        bus.run = 1'b1;
        s = '{OP_NOP, 1'b0, 8'd100, 8'd0};
        issue(s, o, c);
        e = exp_q.pop_front();
        checks++;
        if (o !== e || c !== model_cnt) begin
            failures++;
            $display("FAIL timeout_if: got %h cnt %0d required %h cnt %0d", o, c, e, model_cnt);
        end
        repeat (4) begin
            @(negedge clk);
            #1;
            if (bus.mem_req || bus.busy || !bus.err) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL timeout_hold: mem_req %b busy %b err %b required 0 0 1",
                     bus.mem_req, bus.busy, bus.err);
        end
        do_reset();
        bus.run = 1'b1;
        s = '{OP_NOP, 1'b0, 8'(TIMEOUT - 1), 8'd0};
        issue(s, o, c);
        e = exp_q.pop_front();
        checks++;
        if (o !== e || c !== model_cnt) begin
            failures++;
            $display("FAIL timeout_if_last_ready: got %h cnt %0d required %h cnt %0d", o, c, e, model_cnt);
        end
        s = '{OP_LW, 1'b0, 8'd0, 8'(TIMEOUT - 1)};
        issue(s, o, c);
        e = exp_q.pop_front();
        checks++;
        if (o !== e || c !== model_cnt) begin
            failures++;
            $display("FAIL timeout_mem_last_ready: got %h cnt %0d required %h cnt %0d", o, c, e, model_cnt);
        end
    endtask

    task automatic test_illegal();
        stim_t s;
        rec_t o, e;
        logic [CNT_W-1:0] c;
        do_reset();
        bus.run = 1'b1;
        s = '{6'b010101, 1'b0, 8'd0, 8'd0};
        issue(s, o, c);
        e = exp_q.pop_front();
        checks++;
        if (o !== e || c !== model_cnt || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL illegal: got %h cnt %0d busy %b required %h cnt %0d busy 0",
                     o, c, bus.busy, e, model_cnt);
        end
    endtask

    task automatic test_halt();
        stim_t s;
        rec_t o, e;
        logic [CNT_W-1:0] c;
        bit bad = 0;
        do_reset();
        bus.run = 1'b1;
        s = '{OP_ADDI, 1'b0, 8'd0, 8'd0};
        issue(s, o, c);
        e = exp_q.pop_front();
        checks++;
        if (o !== e || c !== model_cnt) begin
            failures++;
            $display("FAIL halt_pre: got %h cnt %0d required %h cnt %0d", o, c, e, model_cnt);
        end
        s = '{OP_HALT, 1'b0, 8'd1, 8'd0};
        issue(s, o, c);
        e = exp_q.pop_front();
        checks++;
        if (o !== e || c !== model_cnt) begin
            failures++;
            $display("FAIL halt_rec: got %h cnt %0d required %h cnt %0d", o, c, e, model_cnt);
        end
        bus.run = 1'b0;
        @(negedge clk);
        bus.run = 1'b1;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (!bus.halted || bus.mem_req || bus.busy || bus.err || bus.instr_cnt !== model_cnt) bad = 1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL halt_hold: halted %b mem_req %b busy %b cnt %0d required 1 0 0 cnt %0d",
                     bus.halted, bus.mem_req, bus.busy, bus.instr_cnt, model_cnt);
        end
    endtask

    task automatic test_async_reset();
        stim_t s;
        rec_t o, e;
        logic [CNT_W-1:0] c;
        logic [31:0] vec;
        bit ir_seen = 0, reached = 0;
        int in_mem = 0;
        do_reset();
        bus.run = 1'b1;
        s = '{OP_ADDI, 1'b0, 8'd0, 8'd0};
        issue(s, o, c);
        e = exp_q.pop_front();
        checks++;
        if (o !== e || c !== model_cnt) begin
            failures++;
            $display("FAIL arst_pre: got %h cnt %0d required %h cnt %0d", o, c, e, model_cnt);
        end
        bus.opcode = OP_SW;
        for (int k = 0; k < 30 && !reached; k++) begin
            @(negedge clk);
            #1;
            bus.mem_ready = bus.mem_req && !ir_seen;
            #1;
            if (bus.ir_we) ir_seen = 1;
            if (bus.mem_we) in_mem++;
            if (in_mem == 2) reached = 1;
        end
        checks++;
        if (reached !== 1'b1) begin
            failures++;
            $display("FAIL arst_reach_mem: reached %b required 1", reached);
        end
        rst = 1'b1;
        #1;
        vec = {bus.ir_we, bus.alu_op, bus.ex_en, bus.mem_req, bus.mem_we, bus.reg_we,
               bus.wb_sel, bus.pc_we, bus.pc_sel, bus.busy, bus.halted, bus.err, 12'd0};
        checks++;
        if (vec !== 32'd0 || bus.instr_cnt !== '0) begin
            failures++;
            $display("FAIL arst_outputs: got %h cnt %0d required 0", vec, bus.instr_cnt);
        end
        @(negedge clk);
        rst       = 1'b0;
        model_cnt = '0;
        exp_q.delete();
        bus.mem_ready = 1'b0;
        bus.run       = 1'b1;
        s = '{OP_ALU, 1'b0, 8'd0, 8'd0};
        issue(s, o, c);
        e = exp_q.pop_front();
        checks++;
        if (o !== e || c !== model_cnt) begin
            failures++;
            $display("FAIL arst_restart: got %h cnt %0d required %h cnt %0d", o, c, e, model_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch();
        test_back_to_back();
        test_timeout();
        test_illegal();
        test_halt();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
